// File: rtl/otg_hpi_pkg.sv
// otg_hpi_pkg: shared types and constants for the CY7C67200 HPI sequencer.
// Contents: the bus-cycle FSM state enum, HPI register select codes, the
// 16-bit HPI data word type and a small max helper used to size the
// timing counter.
package otg_hpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    typedef logic [15:0] hpi_word_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/otg_hpi_sequencer_if.sv
// otg_hpi_sequencer_if: the two requester ports, their response channels,
// the OTG HPI pad signals and the busy flag. The sequencer uses the slave
// modport; the fabric side (or a bench) uses master.
interface otg_hpi_sequencer_if;
    import otg_hpi_pkg::*;

    logic       req0_valid;
    logic       req0_ready;
    logic       req0_write;
    logic [1:0] req0_addr;
    hpi_word_t  req0_wdata;
    logic       rsp0_valid;
    hpi_word_t  rsp0_rdata;

    logic       req1_valid;
    logic       req1_ready;
    logic       req1_write;
    logic [1:0] req1_addr;
    hpi_word_t  req1_wdata;
    logic       rsp1_valid;
    hpi_word_t  rsp1_rdata;

    logic       otg_hpi_cs_n;
    logic [1:0] otg_hpi_addr;
    logic       otg_hpi_r_n;
    logic       otg_hpi_w_n;
    hpi_word_t  otg_hpi_data_out;
    logic       otg_hpi_data_oe;
    hpi_word_t  otg_hpi_data_in;

    logic       busy;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  otg_hpi_data_in,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output otg_hpi_cs_n, otg_hpi_addr, otg_hpi_r_n, otg_hpi_w_n,
        output otg_hpi_data_out, otg_hpi_data_oe,
        output busy
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output otg_hpi_data_in,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  otg_hpi_cs_n, otg_hpi_addr, otg_hpi_r_n, otg_hpi_w_n,
        input  otg_hpi_data_out, otg_hpi_data_oe,
        input  busy
    );

endinterface

// File: rtl/hpi_rr_arbiter.sv
// hpi_rr_arbiter: 2-way grant for the shared HPI bus.
// Macro OTG_HPI_ROUND_ROBIN_EN: when defined, contention goes to the
// requester that was not granted last; otherwise req0 always wins and no
// last_grant input exists.
module hpi_rr_arbiter (
    input  logic [1:0] valid,
`ifdef OTG_HPI_ROUND_ROBIN_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);

    // One-hot grant; a lone valid requester always wins
    always_comb begin
        grant = 2'b00;
`ifdef OTG_HPI_ROUND_ROBIN_EN
        if (valid[0] && valid[1])
            grant = last_grant ? 2'b01 : 2'b10;
        else if (valid[0])
            grant = 2'b01;
        else if (valid[1])
            grant = 2'b10;
`else
        if (valid[0])
            grant = 2'b01;
        else if (valid[1])
            grant = 2'b10;
`endif
    end

endmodule

// File: rtl/otg_hpi_sequencer.sv
// otg_hpi_sequencer: generates CY7C67200 HPI bus cycles for two requesters
// (0 = NIOS bridge, 1 = keycode poller) with parameterised setup, strobe,
// hold and turnaround timing. All pad outputs are registered.
// Macro OTG_HPI_ROUND_ROBIN_EN selects round-robin arbitration; undefined
// gives fixed priority to req0.
module otg_hpi_sequencer
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int TURN_CYCLES   = 2
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    otg_hpi_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TURN_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 || TURN_CYCLES < 1) begin : g_param_check
        $error("otg_hpi_sequencer: all timing parameters must be at least 1");
    end

    hpi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             owner;
    logic [1:0]       valid;
    logic [1:0]       grant;
    logic             handshake;
    logic             sel_write;
    logic [1:0]       sel_addr;
    hpi_word_t        sel_wdata;

`ifdef OTG_HPI_ROUND_ROBIN_EN
    logic             last_grant;
`endif

    assign valid = {bus.req1_valid, bus.req0_valid};

    hpi_rr_arbiter u_arbiter (
        .valid      (valid),
`ifdef OTG_HPI_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant      (grant)
    );

    assign handshake      = (state == IDLE) && !reset_reset && (grant != 2'b00);
    assign bus.req0_ready = handshake && grant[0];
    assign bus.req1_ready = handshake && grant[1];

    assign sel_write = grant[1] ? bus.req1_write : bus.req0_write;
    assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;

    // Bus-cycle FSM: every pad output is set on the edge that enters the
    // state it belongs to, so the pins are registered and line up with state
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            is_write             <= 1'b0;
            owner                <= 1'b0;
`ifdef OTG_HPI_ROUND_ROBIN_EN
            last_grant           <= 1'b1;
`endif
            bus.otg_hpi_cs_n     <= 1'b1;
            bus.otg_hpi_r_n      <= 1'b1;
            bus.otg_hpi_w_n      <= 1'b1;
            bus.otg_hpi_addr     <= 2'd0;
            bus.otg_hpi_data_out <= '0;
            bus.otg_hpi_data_oe  <= 1'b0;
            bus.rsp0_valid       <= 1'b0;
            bus.rsp1_valid       <= 1'b0;
            bus.rsp0_rdata       <= '0;
            bus.rsp1_rdata       <= '0;
            bus.busy             <= 1'b0;
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (handshake) begin
                        state               <= SETUP;
                        cnt                 <= SETUP_LOAD;
                        is_write            <= sel_write;
                        owner               <= grant[1];
`ifdef OTG_HPI_ROUND_ROBIN_EN
                        last_grant          <= grant[1];
`endif
                        bus.otg_hpi_cs_n    <= 1'b0;
                        bus.otg_hpi_addr    <= sel_addr;
                        bus.otg_hpi_data_oe <= sel_write;
                        if (sel_write)
                            bus.otg_hpi_data_out <= sel_wdata;
                        bus.busy            <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LOAD;
                        if (is_write)
                            bus.otg_hpi_w_n <= 1'b0;
                        else
                            bus.otg_hpi_r_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state           <= HOLD;
                        cnt             <= HOLD_LOAD;
                        bus.otg_hpi_w_n <= 1'b1;
                        bus.otg_hpi_r_n <= 1'b1;
                        if (owner) begin
                            bus.rsp1_valid <= 1'b1;
                            if (!is_write)
                                bus.rsp1_rdata <= bus.otg_hpi_data_in;
                        end else begin
                            bus.rsp0_valid <= 1'b1;
                            if (!is_write)
                                bus.rsp0_rdata <= bus.otg_hpi_data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state               <= TURN;
                        cnt                 <= TURN_LOAD;
                        bus.otg_hpi_cs_n    <= 1'b1;
                        bus.otg_hpi_data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
